// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int unsigned DataWidth = 32;
  localparam logic [DataWidth-1:0] InstNop = 32'h0000_0013;

  typedef enum logic [1:0] {
    IfIdle = 2'd0,
    IfReq  = 2'd1,
    IfDrop = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [DataWidth-1:0] pc;
    logic [DataWidth-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous {pc, inst} FIFO between fetch and decode; head is read straight from storage.
module if_fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  fetch_entry_t           wdata_i,
  input  logic                   pop_i,
  output logic [$clog2(Depth):0] count_o,
  output fetch_entry_t           head_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]   count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Depth is a power of two, so pointers wrap by natural overflow.
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + (PtrW+1)'(push_i) - (PtrW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC capture, imem req/ack handshake, flush handling, decode FIFO.
// Define FETCH_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counter outputs.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [DataWidth-1:0] pc_i,
  input  logic [5:0]           stall,
  input  logic                 flush,
  output logic                 imem_req,
  output logic [DataWidth-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [DataWidth-1:0] imem_rdata,
  output logic                 fetch_stall_req,
`ifdef FETCH_PERF_EN
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_stall_cnt,
`endif
  output logic                 id_valid,
  output logic [DataWidth-1:0] id_pc,
  output logic [DataWidth-1:0] id_inst
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;

  if_state_e            state_q, state_d;
  logic                 req_q, req_d;
  logic [DataWidth-1:0] addr_q, addr_d;

  logic [CntW-1:0] fifo_count;
  fetch_entry_t    fifo_head;
  logic            push, pop, issue;
  logic [31:0]     occ_next;

  // Only stall[1] (hold IF/ID) matters here.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  assign id_valid = (fifo_count != '0);
  assign push     = (state_q == IfReq) && imem_ack && !flush;
  assign pop      = id_valid && !stall[1] && !flush;
  assign occ_next = 32'(fifo_count) + 32'(push) - 32'(pop);
  assign issue    = !flush && ((state_q == IfIdle) || ((state_q == IfReq) && imem_ack)) &&
                    (occ_next < BUF_DEPTH);

  assign fetch_stall_req = !issue && !flush;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    if (issue) begin
      state_d = IfReq;
      req_d   = 1'b1;
      addr_d  = pc_i;
    end else begin
      unique case (state_q)
        IfReq: begin
          if (imem_ack) begin
            state_d = IfIdle;
            req_d   = 1'b0;
          end else if (flush) begin
            // Request must complete on the bus; its data is now stale.
            state_d = IfDrop;
          end
        end
        IfDrop: begin
          if (imem_ack) begin
            state_d = IfIdle;
            req_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IfIdle;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  if_fetch_fifo #(
    .Depth (BUF_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .clear_i (flush),
    .push_i  (push),
    .wdata_i ('{pc: addr_q, inst: imem_rdata}),
    .pop_i   (pop),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign id_pc   = id_valid ? fifo_head.pc   : '0;
  assign id_inst = id_valid ? fifo_head.inst : InstNop;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_q + 32'(push);
      perf_stall_q <= perf_stall_q + 32'(fetch_stall_req);
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
